// File: rtl/lcd_pkg.sv
// Shared definitions for the RGB-LCD path.
//   - rgb565_t and the eight RGB565 bar colours
//   - default 480x272 panel timing (sync, porches, active area)
//   - bar_color(): maps a bar index to its RGB565 colour
package lcd_pkg;

    typedef logic [15:0] rgb565_t;

    localparam rgb565_t WHITE   = 16'hFFFF;
    localparam rgb565_t BLACK   = 16'h0000;
    localparam rgb565_t RED     = 16'hF800;
    localparam rgb565_t GREEN   = 16'h07E0;
    localparam rgb565_t BLUE    = 16'h001F;
    localparam rgb565_t CYAN    = 16'h07FF;
    localparam rgb565_t MAGENTA = 16'hF81F;
    localparam rgb565_t YELLOW  = 16'hFFE0;

    localparam int unsigned LCD_H_SYNC  = 41;
    localparam int unsigned LCD_H_BACK  = 2;
    localparam int unsigned LCD_H_DISP  = 480;
    localparam int unsigned LCD_H_FRONT = 2;
    localparam int unsigned LCD_V_SYNC  = 10;
    localparam int unsigned LCD_V_BACK  = 2;
    localparam int unsigned LCD_V_DISP  = 272;
    localparam int unsigned LCD_V_FRONT = 2;

    // Left-to-right order of the test-pattern bars.
    typedef enum logic [2:0] {
        BarWhite,
        BarBlack,
        BarRed,
        BarGreen,
        BarBlue,
        BarCyan,
        BarMagenta,
        BarYellow
    } bar_e;

    function automatic rgb565_t bar_color(input bar_e bar);
        rgb565_t c;
        unique case (bar)
            BarWhite:   c = WHITE;
            BarBlack:   c = BLACK;
            BarRed:     c = RED;
            BarGreen:   c = GREEN;
            BarBlue:    c = BLUE;
            BarCyan:    c = CYAN;
            BarMagenta: c = MAGENTA;
            BarYellow:  c = YELLOW;
            default:    c = BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/lcd_pattern_gen.sv
// Vertical colour-bar generator used in place of the pixel source.
// Only compiled when LCD_TEST_PATTERN_EN is defined.
// Ports:
//   lcd_clk     in   pixel clock
//   rst_n       in   asynchronous active-low reset
//   pixel_xpos  in   requested column (valid with data_req)
//   bar_rgb     out  RGB565 bar colour for the column requested last cycle
`ifdef LCD_TEST_PATTERN_EN
module lcd_pattern_gen
    import lcd_pkg::*;
#(
    parameter int unsigned H_DISP = LCD_H_DISP
) (
    input  logic        lcd_clk,
    input  logic        rst_n,
    input  logic [10:0] pixel_xpos,
    output logic [15:0] bar_rgb
);

    // Eight bars; guard against a degenerate zero-width bar on tiny panels.
    localparam int unsigned BAR_W = (H_DISP / 8 > 0) ? H_DISP / 8 : 1;

    logic [10:0] xpos_q;
    bar_e        bar_idx;

    // One-cycle delay lines the bar up with lcd_de, like the real pixel source.
    always_ff @(posedge lcd_clk or negedge rst_n) begin
        if (!rst_n) begin
            xpos_q <= '0;
        end else begin
            xpos_q <= pixel_xpos;
        end
    end

    // Threshold compare instead of a divider; columns past 8*BAR_W stay in the last bar.
    always_comb begin
        bar_idx = BarWhite;
        for (int i = 1; i < 8; i++) begin
            if (xpos_q >= 11'(i * BAR_W)) begin
                bar_idx = bar_e'(i[2:0]);
            end
        end
    end

    assign bar_rgb = bar_color(bar_idx);

endmodule
`endif

// File: rtl/lcd_timing_gen.sv
// RGB-LCD timing master: horizontal/vertical counters, sync, DE, pixel request.
// Build option: LCD_TEST_PATTERN_EN replaces pixel_data with 8 vertical colour bars.
// Ports:
//   lcd_clk      in   pixel clock
//   rst_n        in   asynchronous active-low reset
//   pixel_data   in   RGB565 from pixel source, registered 1 cycle after xpos/ypos
//   pixel_xpos   out  requested column, 0 when data_req=0
//   pixel_ypos   out  requested row, 0 when data_req=0
//   h_disp       out  constant H_DISP
//   v_disp       out  constant V_DISP
//   data_req     out  coordinate valid, leads lcd_de by one cycle
//   frame_start  out  one-cycle pulse at h_cnt=0, v_cnt=0
//   lcd_hs       out  horizontal sync, active-low
//   lcd_vs       out  vertical sync, active-low
//   lcd_de       out  data enable
//   lcd_rgb      out  panel pixel bus
//   lcd_bl       out  backlight enable
module lcd_timing_gen
    import lcd_pkg::*;
#(
    parameter int unsigned H_SYNC  = LCD_H_SYNC,
    parameter int unsigned H_BACK  = LCD_H_BACK,
    parameter int unsigned H_DISP  = LCD_H_DISP,
    parameter int unsigned H_FRONT = LCD_H_FRONT,
    parameter int unsigned V_SYNC  = LCD_V_SYNC,
    parameter int unsigned V_BACK  = LCD_V_BACK,
    parameter int unsigned V_DISP  = LCD_V_DISP,
    parameter int unsigned V_FRONT = LCD_V_FRONT
) (
    input  logic        lcd_clk,
    input  logic        rst_n,
    input  logic [15:0] pixel_data,
    output logic [10:0] pixel_xpos,
    output logic [10:0] pixel_ypos,
    output logic [10:0] h_disp,
    output logic [10:0] v_disp,
    output logic        data_req,
    output logic        frame_start,
    output logic        lcd_hs,
    output logic        lcd_vs,
    output logic        lcd_de,
    output logic [15:0] lcd_rgb,
    output logic        lcd_bl
);

    localparam int unsigned H_TOT = H_SYNC + H_BACK + H_DISP + H_FRONT;
    localparam int unsigned V_TOT = V_SYNC + V_BACK + V_DISP + V_FRONT;
    localparam int unsigned HS0   = H_SYNC + H_BACK;
    localparam int unsigned VS0   = V_SYNC + V_BACK;

    localparam logic [10:0] H_LAST    = 11'(H_TOT - 1);
    localparam logic [10:0] V_LAST    = 11'(V_TOT - 1);
    localparam logic [10:0] H_SYNC_W  = 11'(H_SYNC);
    localparam logic [10:0] V_SYNC_W  = 11'(V_SYNC);
    localparam logic [10:0] H_DE_BEG  = 11'(HS0);
    localparam logic [10:0] H_DE_END  = 11'(HS0 + H_DISP);
    localparam logic [10:0] H_REQ_BEG = 11'(HS0 - 1);
    localparam logic [10:0] H_REQ_END = 11'(HS0 + H_DISP - 1);
    localparam logic [10:0] V_ACT_BEG = 11'(VS0);
    localparam logic [10:0] V_ACT_END = 11'(VS0 + V_DISP);

    // Requests start one clock before DE, which must not land inside HS.
    if (H_BACK < 1) begin : g_bad_h_back
        $error("lcd_timing_gen: H_BACK must be at least 1");
    end
    if (H_TOT > 2047) begin : g_bad_h_tot
        $error("lcd_timing_gen: H_TOT must not exceed 2047");
    end
    if (V_TOT > 2047) begin : g_bad_v_tot
        $error("lcd_timing_gen: V_TOT must not exceed 2047");
    end

    logic [10:0] h_cnt_q, h_cnt_d;
    logic [10:0] v_cnt_q, v_cnt_d;
    logic        bl_q;
    logic        line_active;
    logic        de_win;
    logic        req_win;
    logic [15:0] src_rgb;

    always_comb begin
        h_cnt_d = h_cnt_q + 11'd1;
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST) ? 11'd0 : v_cnt_q + 11'd1;
        end
    end

    always_ff @(posedge lcd_clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
            bl_q    <= 1'b0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            bl_q    <= 1'b1;
        end
    end

    assign line_active = (v_cnt_q >= V_ACT_BEG) && (v_cnt_q < V_ACT_END);
    assign de_win      = line_active && (h_cnt_q >= H_DE_BEG) && (h_cnt_q < H_DE_END);
    assign req_win     = line_active && (h_cnt_q >= H_REQ_BEG) && (h_cnt_q < H_REQ_END);

    // Counters already read 0 in reset, so the decode itself is gated by rst_n
    // to hold the panel pins idle rather than emitting a frame_start / sync.
    always_comb begin
        lcd_hs      = 1'b1;
        lcd_vs      = 1'b1;
        lcd_de      = 1'b0;
        data_req    = 1'b0;
        frame_start = 1'b0;
        pixel_xpos  = '0;
        pixel_ypos  = '0;
        if (rst_n) begin
            lcd_hs      = (h_cnt_q >= H_SYNC_W);
            lcd_vs      = (v_cnt_q >= V_SYNC_W);
            lcd_de      = de_win;
            data_req    = req_win;
            frame_start = (h_cnt_q == 11'd0) && (v_cnt_q == 11'd0);
            if (req_win) begin
                pixel_xpos = h_cnt_q - H_REQ_BEG;
                pixel_ypos = v_cnt_q - V_ACT_BEG;
            end
        end
    end

`ifdef LCD_TEST_PATTERN_EN
    lcd_pattern_gen #(
        .H_DISP (H_DISP)
    ) u_pattern_gen (
        .lcd_clk    (lcd_clk),
        .rst_n      (rst_n),
        .pixel_xpos (pixel_xpos),
        .bar_rgb    (src_rgb)
    );
`else
    assign src_rgb = pixel_data;
`endif

    // Source data is already registered upstream; only the DE mux sits in front of the pins.
    assign lcd_rgb = lcd_de ? src_rgb : 16'h0000;
    assign lcd_bl  = bl_q;
    assign h_disp  = 11'(H_DISP);
    assign v_disp  = 11'(V_DISP);

endmodule

// File: tb/tb_lcd_timing_gen.sv
module tb_lcd_timing_gen;

    // Default 480x272 panel.
    localparam int D_HS = 41, D_HB = 2, D_HD = 480, D_HF = 2;
    localparam int D_VS = 10, D_VB = 2, D_VD = 272, D_VF = 2;
    localparam int D_HT = D_HS + D_HB + D_HD + D_HF;
    localparam int D_VT = D_VS + D_VB + D_VD + D_VF;
    // Small panel so whole frames fit in a short run.
    localparam int S_HS = 4, S_HB = 2, S_HD = 16, S_HF = 3;
    localparam int S_VS = 2, S_VB = 2, S_VD = 6, S_VF = 1;
    localparam int S_HT = S_HS + S_HB + S_HD + S_HF;
    localparam int S_VT = S_VS + S_VB + S_VD + S_VF;

    logic lcd_clk = 1'b0;
    always #5 lcd_clk = ~lcd_clk;

    logic rst_n_d, rst_n_s, ff_mode;

    logic [15:0] pixel_data_d, pixel_data_s, lcd_rgb_d, lcd_rgb_s;
    logic [10:0] pixel_xpos_d, pixel_ypos_d, h_disp_d, v_disp_d;
    logic [10:0] pixel_xpos_s, pixel_ypos_s, h_disp_s, v_disp_s;
    logic data_req_d, frame_start_d, lcd_hs_d, lcd_vs_d, lcd_de_d, lcd_bl_d;
    logic data_req_s, frame_start_s, lcd_hs_s, lcd_vs_s, lcd_de_s, lcd_bl_s;

    lcd_timing_gen u_dut_d (
        .lcd_clk (lcd_clk), .rst_n (rst_n_d), .pixel_data (pixel_data_d),
        .pixel_xpos (pixel_xpos_d), .pixel_ypos (pixel_ypos_d),
        .h_disp (h_disp_d), .v_disp (v_disp_d), .data_req (data_req_d),
        .frame_start (frame_start_d), .lcd_hs (lcd_hs_d), .lcd_vs (lcd_vs_d),
        .lcd_de (lcd_de_d), .lcd_rgb (lcd_rgb_d), .lcd_bl (lcd_bl_d)
    );

    lcd_timing_gen #(
        .H_SYNC (S_HS), .H_BACK (S_HB), .H_DISP (S_HD), .H_FRONT (S_HF),
        .V_SYNC (S_VS), .V_BACK (S_VB), .V_DISP (S_VD), .V_FRONT (S_VF)
    ) u_dut_s (
        .lcd_clk (lcd_clk), .rst_n (rst_n_s), .pixel_data (pixel_data_s),
        .pixel_xpos (pixel_xpos_s), .pixel_ypos (pixel_ypos_s),
        .h_disp (h_disp_s), .v_disp (v_disp_s), .data_req (data_req_s),
        .frame_start (frame_start_s), .lcd_hs (lcd_hs_s), .lcd_vs (lcd_vs_s),
        .lcd_de (lcd_de_s), .lcd_rgb (lcd_rgb_s), .lcd_bl (lcd_bl_s)
    );

    // Pixel-source models: register the requested coordinate into pixel_data.
    always_ff @(posedge lcd_clk) begin
        pixel_data_d <= ff_mode ? 16'hFFFF : {pixel_xpos_d[4:0], pixel_ypos_d[5:0], 5'b0};
        pixel_data_s <= ff_mode ? 16'hFFFF : {pixel_xpos_s[4:0], pixel_ypos_s[5:0], 5'b0};
    end

    // Reference counters and backlight.
    int   hm_d, vm_d, hm_s, vm_s;
    logic blm_d, blm_s;

    always_ff @(posedge lcd_clk or negedge rst_n_d) begin
        if (!rst_n_d) begin
            hm_d <= 0; vm_d <= 0; blm_d <= 1'b0;
        end else begin
            blm_d <= 1'b1;
            hm_d  <= (hm_d == D_HT - 1) ? 0 : hm_d + 1;
            if (hm_d == D_HT - 1) vm_d <= (vm_d == D_VT - 1) ? 0 : vm_d + 1;
        end
    end

    always_ff @(posedge lcd_clk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            hm_s <= 0; vm_s <= 0; blm_s <= 1'b0;
        end else begin
            blm_s <= 1'b1;
            hm_s  <= (hm_s == S_HT - 1) ? 0 : hm_s + 1;
            if (hm_s == S_HT - 1) vm_s <= (vm_s == S_VT - 1) ? 0 : vm_s + 1;
        end
    end

    int checks = 0;
    int errors = 0;
    int vs_low_d = 0;
    logic [15:0] sb_d[$];
    logic [15:0] sb_s[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] exp_rgb(input int x, input int y, input int hd);
        logic [10:0] xv, yv;
        logic [15:0] pass, bar;
        int idx;
        xv   = 11'(x);
        yv   = 11'(y);
        pass = ff_mode ? 16'hFFFF : {xv[4:0], yv[5:0], 5'b0};
        idx  = x / (hd / 8);
        if (idx > 7) idx = 7;
        case (idx)
            0:       bar = 16'hFFFF;
            1:       bar = 16'h0000;
            2:       bar = 16'hF800;
            3:       bar = 16'h07E0;
            4:       bar = 16'h001F;
            5:       bar = 16'h07FF;
            6:       bar = 16'hF81F;
            default: bar = 16'hFFE0;
        endcase
`ifdef LCD_TEST_PATTERN_EN
        return bar;
`else
        return pass;
`endif
    endfunction

    task automatic check_inst(
        input string tag, input logic rst, input int h, input int v,
        input int hs_w, input int hb, input int hd, input int vs_w, input int vb, input int vd,
        input logic blm, input logic o_hs, input logic o_vs, input logic o_de,
        input logic o_req, input logic o_fs, input logic o_bl,
        input logic [10:0] o_x, input logic [10:0] o_y, input logic [15:0] o_rgb,
        output logic e_de, output logic e_req, output int e_x, output int e_y
    );
        int   hs0, vs0;
        logic act;
        hs0   = hs_w + hb;
        vs0   = vs_w + vb;
        act   = rst && (v >= vs0) && (v < vs0 + vd);
        e_de  = act && (h >= hs0) && (h < hs0 + hd);
        e_req = act && (h >= hs0 - 1) && (h < hs0 + hd - 1);
        e_x   = e_req ? h - (hs0 - 1) : 0;
        e_y   = e_req ? v - vs0 : 0;
        chk({tag, "_hs"},   o_hs,  rst ? (h >= hs_w) : 1'b1);
        chk({tag, "_vs"},   o_vs,  rst ? (v >= vs_w) : 1'b1);
        chk({tag, "_de"},   o_de,  e_de);
        chk({tag, "_req"},  o_req, e_req);
        chk({tag, "_fs"},   o_fs,  rst && (h == 0) && (v == 0));
        chk({tag, "_bl"},   o_bl,  blm);
        chk({tag, "_xpos"}, o_x,   e_x);
        chk({tag, "_ypos"}, o_y,   e_y);
        if (!e_de) chk({tag, "_rgb_blank"}, o_rgb, 0);
    endtask

    // Advance to the next sample point and check both DUTs against the model.
    task automatic step();
        logic de, rq;
        int   x, y;
        @(negedge lcd_clk);
        check_inst("d", rst_n_d, hm_d, vm_d, D_HS, D_HB, D_HD, D_VS, D_VB, D_VD, blm_d,
                   lcd_hs_d, lcd_vs_d, lcd_de_d, data_req_d, frame_start_d, lcd_bl_d,
                   pixel_xpos_d, pixel_ypos_d, lcd_rgb_d, de, rq, x, y);
        if (!rst_n_d) begin
            sb_d.delete();
        end else begin
            if (de) begin
                chk("d_sb_avail", sb_d.size() > 0, 1'b1);
                if (sb_d.size() > 0) chk("d_rgb", lcd_rgb_d, sb_d.pop_front());
            end
            if (rq) sb_d.push_back(exp_rgb(x, y, D_HD));
        end
        if (rst_n_d && lcd_vs_d === 1'b0) vs_low_d++;

        check_inst("s", rst_n_s, hm_s, vm_s, S_HS, S_HB, S_HD, S_VS, S_VB, S_VD, blm_s,
                   lcd_hs_s, lcd_vs_s, lcd_de_s, data_req_s, frame_start_s, lcd_bl_s,
                   pixel_xpos_s, pixel_ypos_s, lcd_rgb_s, de, rq, x, y);
        if (!rst_n_s) begin
            sb_s.delete();
        end else begin
            if (de) begin
                chk("s_sb_avail", sb_s.size() > 0, 1'b1);
                if (sb_s.size() > 0) chk("s_rgb", lcd_rgb_s, sb_s.pop_front());
            end
            if (rq) sb_s.push_back(exp_rgb(x, y, S_HD));
        end
    endtask

    // Measure small-panel frame length and DE count from the current frame_start sample.
    task automatic measure_frame(input string tag);
        int p, dc;
        p  = 0;
        dc = 0;
        do begin
            if (lcd_de_s === 1'b1) dc++;
            p++;
            step();
        end while (frame_start_s !== 1'b1 && p < 1000);
        chk({tag, "_period"}, p, S_HT * S_VT);
        chk({tag, "_de_count"}, dc, S_HD * S_VD);
    endtask

    initial begin
        int n, p, k, cnt, last_x, last_h, nz;
        rst_n_d = 1'b0;
        rst_n_s = 1'b0;
        ff_mode = 1'b0;
        repeat (3) step();
        chk("h_disp", h_disp_d, 480);
        chk("v_disp", v_disp_d, 272);
        chk("h_disp_s", h_disp_s, S_HD);

        @(posedge lcd_clk);
        #2;
        rst_n_d = 1'b1;
        rst_n_s = 1'b1;
        step();
        chk("first_fs", frame_start_d, 1'b1);
        chk("first_hs", lcd_hs_d, 1'b0);
        chk("first_vs", lcd_vs_d, 1'b0);
        chk("first_bl", lcd_bl_d, 1'b0);
        step();
        chk("bl_on", lcd_bl_d, 1'b1);
        chk("fs_pulse", frame_start_d, 1'b0);

        // HS low width and line period.
        n = 2;
        while (n < 2000) begin
            step();
            if (lcd_hs_d !== 1'b0) break;
            n++;
        end
        chk("hs_low", n, 41);
        p = n;
        while (lcd_hs_d !== 1'b0 && p < 2000) begin
            p++;
            step();
        end
        chk("line_period", p, 525);

        // First active line.
        k = 0;
        while (data_req_d !== 1'b1 && k < 20000) begin
            step();
            k++;
        end
        chk("req_seen", data_req_d, 1'b1);
        chk("req_h", hm_d, 42);
        chk("req_v", vm_d, 12);
        chk("req_xpos", pixel_xpos_d, 0);
        chk("req_ypos", pixel_ypos_d, 0);
        chk("req_de_low", lcd_de_d, 1'b0);
        chk("vs_low", vs_low_d, 10 * 525);
        step();
        chk("de_rise", lcd_de_d, 1'b1);
        chk("de_rise_h", hm_d, 43);
        cnt    = 1;
        last_x = 0;
        last_h = 0;
        while (data_req_d === 1'b1 && cnt < 1000) begin
            last_x = pixel_xpos_d;
            last_h = hm_d;
            cnt++;
            step();
        end
        chk("req_count", cnt, 480);
        chk("last_xpos", last_x, 479);
        chk("last_req_h", last_h, 521);
        chk("de_last", lcd_de_d, 1'b1);
        step();
        chk("de_fall", lcd_de_d, 1'b0);

        // Whole frames on the small panel.
        k = 0;
        while (frame_start_s !== 1'b1 && k < 1000) begin
            step();
            k++;
        end
        chk("s_fs_seen", frame_start_s, 1'b1);
        measure_frame("s_frame");

        // Blanking with a saturated source.
        @(posedge lcd_clk);
        #2;
        ff_mode = 1'b1;
        nz = 0;
        repeat (300) begin
            step();
            if (lcd_de_s !== 1'b1 && lcd_rgb_s !== 16'h0000) nz++;
        end
        chk("blank_nonzero", nz, 0);
        @(posedge lcd_clk);
        #2;
        ff_mode = 1'b0;

        // Mid-frame reset of the small panel.
        k = 0;
        while (!(hm_s == 10 && vm_s == 5) && k < 1000) begin
            step();
            k++;
        end
        chk("s_mid_reached", (hm_s == 10 && vm_s == 5), 1'b1);
        #2;
        rst_n_s = 1'b0;
        step();
        chk("s_rst_bl", lcd_bl_s, 1'b0);
        chk("s_rst_hs", lcd_hs_s, 1'b1);
        chk("s_rst_vs", lcd_vs_s, 1'b1);
        chk("s_rst_rgb", lcd_rgb_s, 0);
        repeat (2) step();
        @(posedge lcd_clk);
        #2;
        rst_n_s = 1'b1;
        step();
        chk("s_rel_fs", frame_start_s, 1'b1);
        chk("s_rel_bl", lcd_bl_s, 1'b0);
        measure_frame("s_restart");
        chk("s_bl_after", lcd_bl_s, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lcd_timing_gen.md
# lcd_timing_gen

Generates RGB-LCD panel timing: horizontal and vertical counters, sync pulses, and data-enable (DE). It publishes the coordinate of the next pixel to the pixel-source block (`lcd_display`) and returns that block's registered `pixel_data` on `lcd_rgb`, aligned with DE. It sits between the pixel source and the panel pins and is the sole timing master of the LCD path.

## Interface
- `H_SYNC`, 41, HS pulse width (clocks)
- `H_BACK`, 2, horizontal back porch
- `H_DISP`, 480, active pixels per line
- `H_FRONT`, 2, horizontal front porch
- `V_SYNC`, 10, VS pulse width (lines)
- `V_BACK`, 2, vertical back porch
- `V_DISP`, 272, active lines
- `V_FRONT`, 2, vertical front porch

- `lcd_clk`  in  1  pixel clock
- `rst_n`  in  1  reset; asynchronous, active-low
- `pixel_data`  in  16  RGB565 from the pixel source; registered one cycle after `pixel_xpos`/`pixel_ypos`
- `pixel_xpos`  out  11  column of the pixel requested; 0 when `data_req`=0
- `pixel_ypos`  out  11  row of the pixel requested; 0 when `data_req`=0
- `h_disp`  out  11  constant `H_DISP`
- `v_disp`  out  11  constant `V_DISP`
- `data_req`  out  1  coordinate valid; leads `lcd_de` by exactly 1 cycle
- `frame_start`  out  1  1-cycle pulse at `h_cnt`=0, `v_cnt`=0
- `lcd_hs`  out  1  horizontal sync, active-low
- `lcd_vs`  out  1  vertical sync, active-low
- `lcd_de`  out  1  data enable, active-high
- `lcd_rgb`  out  16  panel pixel bus
- `lcd_bl`  out  1  backlight enable

## Operation
- Line total: `H_TOT` = `H_SYNC`+`H_BACK`+`H_DISP`+`H_FRONT`.
- Frame total: `V_TOT` = `V_SYNC`+`V_BACK`+`V_DISP`+`V_FRONT`.
- Active start: `HS0` = `H_SYNC`+`H_BACK`, `VS0` = `V_SYNC`+`V_BACK`.
- `h_cnt` (11 bit) counts 0..`H_TOT`-1 and wraps to 0.
- `v_cnt` (11 bit) increments only when `h_cnt`=`H_TOT`-1, and wraps to 0 after `V_TOT`-1. Both wrap in the same cycle at end of frame.
- Sync: `lcd_hs`=0 while `h_cnt`<`H_SYNC`. `lcd_vs`=0 while `v_cnt`<`V_SYNC`.
- Active line: `VS0` ≤ `v_cnt` < `VS0`+`V_DISP`.
- `lcd_de`=1 when `HS0` ≤ `h_cnt` < `HS0`+`H_DISP` on an active line.
- `data_req`=1 when `HS0`-1 ≤ `h_cnt` < `HS0`+`H_DISP`-1 on an active line.
- `pixel_xpos` = `h_cnt`-(`HS0`-1). `pixel_ypos` = `v_cnt`-`VS0`. Both are forced to 0 outside `data_req`.
- `lcd_rgb` = `lcd_de` ? `pixel_data` : 0.
- `lcd_hs`, `lcd_vs`, `lcd_de`, `data_req`, `pixel_xpos`, `pixel_ypos`, `frame_start`, and `lcd_rgb` are combinational decodes of the counter registers. No logic sits between the pixel source's register and `lcd_rgb` other than the DE mux.
- `lcd_bl` is a register. It is 0 in reset and 1 from the first clock after reset release.

## Timing
- Reset values: `h_cnt`=0, `v_cnt`=0, `lcd_bl`=0.
- While `rst_n`=0, decoded outputs are forced: `lcd_hs`=1, `lcd_vs`=1, `lcd_de`=0, `data_req`=0, `frame_start`=0, `lcd_rgb`=0, `pixel_xpos`=`pixel_ypos`=0.
- First clock after release: `h_cnt`=0, `v_cnt`=0, `frame_start`=1. HS and VS go low in that cycle.
- Latency: a coordinate issued in cycle t appears on `lcd_rgb` with `lcd_de`=1 in cycle t+1.
- Line boundary: the last `data_req` of a line carries `pixel_xpos`=`H_DISP`-1, one cycle before the last DE. `data_req` never spans two lines.
- Reset mid-frame: counters clear immediately (asynchronously). The frame restarts from `h_cnt`=0 and no partial line is resumed.
- Parameter constraints: `H_BACK` ≥ 1 (so `HS0`-1 ≥ `H_SYNC`), `H_TOT` ≤ 2047, `V_TOT` ≤ 2047. These are checked by elaboration-time assertion.

## Configuration
- `LCD_TEST_PATTERN_EN` defined:
  - `lcd_rgb` ignores `pixel_data` and outputs 8 vertical color bars of width `H_DISP`/8, derived from the delayed `pixel_xpos`.
  - Bar order: white, black, red, green, blue, cyan, magenta, yellow.
  - Bars are muxed only during `lcd_de`; `lcd_rgb` is 0 otherwise.
- Not defined: pass-through of `pixel_data` as specified under Operation.

## Structure
- The shared package `lcd_pkg` holds the RGB565 color constants (WHITE, BLACK, RED, GREEN, BLUE, CYAN, MAGENTA, YELLOW) and the default 480x272 timing constants.
- Sub-module `lcd_pattern_gen` holds the bar generator. It is instantiated only under `LCD_TEST_PATTERN_EN`.

## Test plan
- Reset release with default parameters:
  - `frame_start` pulses at the first clock.
  - `lcd_hs` is low for 41 clocks; the line period is 525.
  - `lcd_vs` is low for 10 lines; the frame period is 286 lines × 525 clocks.
- Line 12, first active line:
  - `data_req` rises at `h_cnt`=42 with `pixel_xpos`=0, `pixel_ypos`=0.
  - `lcd_de` rises at `h_cnt`=43.
  - The last request is `pixel_xpos`=479 at `h_cnt`=521; `lcd_de` falls after `h_cnt`=522.
- Pixel-source model returns `pixel_data`={xpos[4:0],ypos[5:0],5'b0} registered → every `lcd_rgb` sample under DE matches its own column and row. Count of DE cycles per frame = 480×272 = 130560.
- Blanking:
  - Drive `pixel_data`=16'hFFFF constantly → `lcd_rgb`=0 whenever `lcd_de`=0.
  - `pixel_ypos` never exceeds 271; `pixel_xpos` never exceeds 479.
- Assert `rst_n` low mid-line at `v_cnt`=100, `h_cnt`=200 for 3 clocks:
  - During reset, outputs take their forced values and `lcd_bl`=0.
  - After release, `frame_start`=1 on the first clock and the full timing sequence repeats.
- Build with `LCD_TEST_PATTERN_EN`:
  - `lcd_rgb` = WHITE for DE columns 0..59, BLACK for columns 60..119, YELLOW for columns 420..479.
  - `pixel_data` has no effect.
